// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder: oversamples MDC/MDIO on the system clock, decodes
// read/write frames for PHY_ADDR and serves a 32 x 16 register file.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int          PREAMBLE_MIN = 32,
  parameter logic [15:0] PHY_ID1      = 16'h0007,
  parameter logic [15:0] PHY_ID2      = 16'hC0F0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MDC,
  input  logic        MDIO_In,
  output logic        MDIO_Out,
  output logic        MDIO_Oe,
  input  logic [15:0] Status_In,
  output logic        Reg_Wr_Valid,
  output logic [4:0]  Reg_Wr_Addr,
  output logic [15:0] Reg_Wr_Data,
  output logic        Frame_Err
);

  typedef enum logic [2:0] {IDLE, ST2, OP, PHYAD, REGAD, TA, WR_DATA, RD_DATA} state_t;

  state_t      state, state_d;
  logic [1:0]  mdc_sync, mdio_sync;
  logic        mdc_prev, mdc_rise, bit_in;
  logic [5:0]  pre_cnt, pre_cnt_d;
  logic [4:0]  bit_cnt, bit_cnt_d;
  logic [15:0] shreg, shreg_d;
  logic        is_read, is_read_d;
  logic [4:0]  reg_addr, reg_addr_d;
  logic        oe_d, out_d, err_d, wr_fire;
  logic [15:0] wr_data, rd_word;
  logic [15:0] regs [32];

  assign mdc_rise = mdc_sync[1] & ~mdc_prev;
  assign bit_in   = mdio_sync[1];
  assign wr_data  = {shreg[14:0], bit_in};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mdc_sync  <= '0;
      mdio_sync <= '0;
      mdc_prev  <= 1'b0;
    end else begin
      mdc_sync  <= {mdc_sync[0], MDC};
      mdio_sync <= {mdio_sync[0], MDIO_In};
      mdc_prev  <= mdc_sync[1];
    end
  end

  always_comb begin
    case (reg_addr)
      5'd1:    rd_word = Status_In;
      5'd2:    rd_word = PHY_ID1;
      5'd3:    rd_word = PHY_ID2;
      default: rd_word = regs[reg_addr];
    endcase
  end

  always_comb begin
    state_d    = state;
    pre_cnt_d  = pre_cnt;
    bit_cnt_d  = bit_cnt;
    shreg_d    = shreg;
    is_read_d  = is_read;
    reg_addr_d = reg_addr;
    oe_d       = MDIO_Oe;
    out_d      = MDIO_Out;
    err_d      = 1'b0;
    wr_fire    = 1'b0;
    if (mdc_rise) begin
      case (state)
        IDLE: begin
          if (bit_in) begin
            if (pre_cnt != 6'd63) pre_cnt_d = pre_cnt + 6'd1;
          end else begin
            pre_cnt_d = '0;
            if (pre_cnt >= 6'(PREAMBLE_MIN)) state_d = ST2;
          end
        end
        ST2: begin
          bit_cnt_d = '0;
          if (bit_in) state_d = OP;
          else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        OP: begin
          shreg_d   = wr_data;
          bit_cnt_d = bit_cnt + 5'd1;
          if (bit_cnt == 5'd1) begin
            bit_cnt_d = '0;
            is_read_d = (wr_data[1:0] == 2'b10);
            if (wr_data[1:0] == 2'b10 || wr_data[1:0] == 2'b01) state_d = PHYAD;
            else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end
        PHYAD: begin
          shreg_d   = wr_data;
          bit_cnt_d = bit_cnt + 5'd1;
          if (bit_cnt == 5'd4) begin
            bit_cnt_d = '0;
            // A foreign address drops silently; its payload can never look like a preamble.
            state_d   = (wr_data[4:0] == PHY_ADDR) ? REGAD : IDLE;
          end
        end
        REGAD: begin
          shreg_d   = wr_data;
          bit_cnt_d = bit_cnt + 5'd1;
          if (bit_cnt == 5'd4) begin
            bit_cnt_d  = '0;
            reg_addr_d = wr_data[4:0];
            state_d    = TA;
          end
        end
        TA: begin
          if (is_read) begin
            shreg_d   = rd_word;
            oe_d      = 1'b1;
            out_d     = 1'b0;
            bit_cnt_d = '0;
            state_d   = RD_DATA;
          end else if (bit_cnt == 5'd1) begin
            bit_cnt_d = '0;
            state_d   = WR_DATA;
          end else begin
            bit_cnt_d = 5'd1;
          end
        end
        WR_DATA: begin
          shreg_d   = wr_data;
          bit_cnt_d = bit_cnt + 5'd1;
          if (bit_cnt == 5'd15) begin
            wr_fire   = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end
        end
        RD_DATA: begin
          if (bit_cnt == 5'd16) begin
            oe_d      = 1'b0;
            out_d     = 1'b0;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            out_d     = shreg[15];
            shreg_d   = {shreg[14:0], 1'b0};
            bit_cnt_d = bit_cnt + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      pre_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      is_read      <= 1'b0;
      reg_addr     <= '0;
      MDIO_Oe      <= 1'b0;
      MDIO_Out     <= 1'b0;
      Frame_Err    <= 1'b0;
      Reg_Wr_Valid <= 1'b0;
      Reg_Wr_Addr  <= '0;
      Reg_Wr_Data  <= '0;
    end else begin
      state        <= state_d;
      pre_cnt      <= pre_cnt_d;
      bit_cnt      <= bit_cnt_d;
      shreg        <= shreg_d;
      is_read      <= is_read_d;
      reg_addr     <= reg_addr_d;
      MDIO_Oe      <= oe_d;
      MDIO_Out     <= out_d;
      Frame_Err    <= err_d;
      Reg_Wr_Valid <= wr_fire;
      if (wr_fire) begin
        Reg_Wr_Addr <= reg_addr;
        Reg_Wr_Data <= wr_data;
      end
    end
  end

  // Reg 0 bit 15 is a soft reset of the whole writable file; IDs and status are never stored.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_fire) begin
      if (reg_addr == 5'd0 && wr_data[15]) begin
        for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (reg_addr != 5'd1 && reg_addr != 5'd2 && reg_addr != 5'd3) begin
        regs[reg_addr] <= wr_data;
      end
    end
  end

endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
PHY-side MDIO management responder (IEEE 802.3 clause 22). Runs on the 50 MHz system clock and oversamples the 1 MHz MDC and MDIO lines driven by the station-management master. Decodes read/write frames addressed to its PHY address against an internal 32 x 16 register file and drives read data back onto MDIO. It serves as the synthesizable PHY model in loopback benches and as an emulated management target.

Parameters:
PHY_ADDR, 5'd1, PHY address this block answers to.
PREAMBLE_MIN, 32, consecutive 1s required before a start-of-frame is accepted.
PHY_ID1, 16'h0007, fixed read-only value of register 2.
PHY_ID2, 16'hC0F0, fixed read-only value of register 3.

Ports:
Clk  in  1  system clock, 50 MHz
Rst  in  1  asynchronous, active-high reset
MDC  in  1  management clock from master, asynchronous to Clk
MDIO_In  in  1  MDIO pad input
MDIO_Out  out  1  MDIO pad output value
MDIO_Oe  out  1  MDIO pad output enable, 1 = responder drives the line
Status_In  in  16  live value returned on reads of register 1
Reg_Wr_Valid  out  1  one-Clk pulse when an addressed write completes
Reg_Wr_Addr  out  5  register address of the completed write
Reg_Wr_Data  out  16  data of the completed write
Frame_Err  out  1  one-Clk pulse on a malformed ST or OP field

Behaviour:
- Reset, asynchronous, all outputs: MDIO_Out=0, MDIO_Oe=0, Reg_Wr_Valid=0, Reg_Wr_Addr=0, Reg_Wr_Data=0, Frame_Err=0. FSM goes to IDLE, preamble count=0, and all writable registers are cleared to 16'h0000.
- MDC and MDIO_In each pass through a 2-flop synchronizer. An MDC rising edge is a synced 0->1 transition. MDIO is sampled from its synced value in the same cycle. MDC high and low phases are each guaranteed to be at least 4 Clk cycles.
- All FSM activity advances only on a detected MDC rising edge ("edge"). Fields are MSB first.
- FSM states: IDLE, ST2, OP, PHYAD, REGAD, TA, WR_DATA, RD_DATA.
- IDLE:
  - A sampled 1 increments the preamble count, saturating at 63.
  - A sampled 0 with count >= PREAMBLE_MIN moves to ST2.
  - A sampled 0 with count < PREAMBLE_MIN clears the count.
- ST2: sampled 1 moves to OP. Sampled 0 pulses Frame_Err and returns to IDLE with count cleared.
- OP: collects 2 bits. 10 = read, 01 = write. 00 or 11 pulses Frame_Err and returns to IDLE.
- PHYAD: collects 5 bits. A mismatch with PHY_ADDR returns to IDLE silently with count cleared and MDIO_Oe held 0. The remaining frame bits cannot re-trigger because 32 ones are required.
- REGAD: collects 5 bits, then moves to TA.
- Read, with edge n = last REGAD bit:
  - Edge n+1: latch the read word and set MDIO_Oe=1, MDIO_Out=0 (TA second bit).
  - Edges n+2..n+17: drive D15..D0.
  - Edge n+18: MDIO_Oe=0, return to IDLE.
  - Outputs change in the Clk cycle after edge detection.
- Read word sources: reg 1 = Status_In (sampled at edge n+1), reg 2 = PHY_ID1, reg 3 = PHY_ID2, others = stored value.
- Write:
  - The two TA bits are consumed and their values ignored.
  - WR_DATA shifts 16 bits.
  - On the 16th bit: update storage, pulse Reg_Wr_Valid for one Clk with Reg_Wr_Addr/Reg_Wr_Data, then return to IDLE.
  - Registers 1, 2, 3 are not updated but still pulse Reg_Wr_Valid.
  - Reg_Wr_Addr/Data hold their last values between pulses.
- Register 0 bit 15 is self-clearing. Writing 1 clears all writable registers (including reg 0) to 0 in the same cycle as the Reg_Wr_Valid pulse. Reg 0 then reads 16'h0000.
- MDIO_Oe is 1 only in read TA2/data phases. It is never asserted in write frames or unaddressed frames.
- Reset mid-frame, any state: immediate IDLE with MDIO_Oe=0. A new frame needs a full preamble.
- Back-to-back frames: the preamble count is 0 on re-entering IDLE, so each frame requires its own PREAMBLE_MIN ones.

Test Plan:
- Write reg 4 = 16'hA5C3 to PHYAD 1, then read reg 4 -> one Reg_Wr_Valid pulse (addr 4, data 16'hA5C3). Read returns TA2=0 and then 16'hA5C3 MSB first. MDIO_Oe high for exactly 17 MDC periods.
- Read reg 2 and reg 3 -> 16'h0007 and 16'hC0F0. Write 16'hFFFF to reg 2 -> pulse issued, re-read still 16'h0007.
- Frame to PHYAD 5 (write reg 4 = 16'h1234) -> no Reg_Wr_Valid, MDIO_Oe stays 0, reg 4 unchanged.
- Preamble of 31 ones, then 01 + read frame -> ignored, no Oe. OP=11 after a valid preamble/ST -> Frame_Err pulse, return to IDLE.
- Write reg 0 = 16'h8000 after reg 4 = 16'h00FF -> reads of reg 0 and reg 4 both return 16'h0000.
- Assert Rst during read data bit D8 -> MDIO_Oe=0 immediately. The next full read of reg 4 returns 16'h0000.
